// File: rtl/bit_usage_monitor.sv
// bit_usage_monitor: per-channel driven/used bit tracker with a snapshot-based,
// handshaked report scan (one channel per beat).
`default_nettype none

module bit_usage_monitor #(
  parameter int WIDTH = 16,
  parameter int NCH   = 2,
  parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       wr_en,
  input  logic [NCH*WIDTH-1:0] wr_mask,
  input  logic [NCH-1:0]       rd_en,
  input  logic [NCH*WIDTH-1:0] rd_mask,
  input  logic                 clear,
  input  logic                 report_req,
  output logic                 busy,
  output logic                 rpt_valid,
  input  logic                 rpt_ready,
  output logic [CHW-1:0]       rpt_chan,
  output logic [WIDTH-1:0]     rpt_unused,
  output logic [WIDTH-1:0]     rpt_undriven,
  output logic [WIDTH-1:0]     rpt_untouched,
  output logic [CNTW-1:0]      rpt_flag_cnt,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CHW-1:0] c_last_idx = CHW'(NCH - 1);

  state_t           r_state, w_state_nxt;
  logic [CHW-1:0]   r_idx, w_idx_nxt;
  logic             w_snap_load;

  logic [WIDTH-1:0] r_drv      [NCH];
  logic [WIDTH-1:0] r_use      [NCH];
  logic [WIDTH-1:0] r_snap_drv [NCH];
  logic [WIDTH-1:0] r_snap_use [NCH];
  logic [WIDTH-1:0] w_drv_nxt  [NCH];
  logic [WIDTH-1:0] w_use_nxt  [NCH];

  logic [WIDTH-1:0] w_sel_drv, w_sel_use;
  logic [WIDTH-1:0] w_unused, w_undriven;
  logic [CNTW-1:0]  w_cnt;
  logic             w_scan;

  // clear discards history but keeps this cycle's strobed events
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_drv_nxt[c] = (clear ? '0 : r_drv[c]) |
                     (wr_en[c] ? wr_mask[c*WIDTH +: WIDTH] : '0);
      w_use_nxt[c] = (clear ? '0 : r_use[c]) |
                     (rd_en[c] ? rd_mask[c*WIDTH +: WIDTH] : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        r_drv[c]      <= '0;
        r_use[c]      <= '0;
        r_snap_drv[c] <= '0;
        r_snap_use[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        r_drv[c] <= w_drv_nxt[c];
        r_use[c] <= w_use_nxt[c];
        if (w_snap_load) begin
          r_snap_drv[c] <= w_drv_nxt[c];
          r_snap_use[c] <= w_use_nxt[c];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_snap_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (report_req) begin
          w_snap_load = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (rpt_ready) begin
          if (r_idx == c_last_idx) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_idx + CHW'(1);
          end
        end
      end
      S_DONE: begin
        w_idx_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_sel_drv = '0;
    w_sel_use = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_idx == CHW'(c)) begin
        w_sel_drv = r_snap_drv[c];
        w_sel_use = r_snap_use[c];
      end
    end
  end

  assign w_scan     = (r_state == S_SCAN);
  assign w_unused   = w_sel_drv & ~w_sel_use;
  assign w_undriven = w_sel_use & ~w_sel_drv;

  always_comb begin
    w_cnt = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_cnt = w_cnt + CNTW'(w_unused[b] | w_undriven[b]);
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign rpt_valid     = w_scan;
  assign rpt_chan      = w_scan ? r_idx : '0;
  assign rpt_unused    = w_scan ? w_unused : '0;
  assign rpt_undriven  = w_scan ? w_undriven : '0;
  assign rpt_untouched = w_scan ? ~(w_sel_drv | w_sel_use) : '0;
  assign rpt_flag_cnt  = w_scan ? w_cnt : '0;

endmodule

`default_nettype wire

// File: tb/tb_bit_usage_monitor.sv
// tb_bit_usage_monitor: randomized and directed checks of bit_usage_monitor
// against a queue-based reference model; a second NCH=1/WIDTH=1 build is also exercised.
`default_nettype none

module tb_bit_usage_monitor;

  localparam int W = 16;
  localparam int N = 2;

  logic          clk, rst;
  logic [N-1:0]  wr_en, rd_en;
  logic [N*W-1:0] wr_mask, rd_mask;
  logic          clear, report_req, rpt_ready;
  logic          busy, rpt_valid, done;
  logic [0:0]    rpt_chan;
  logic [W-1:0]  rpt_unused, rpt_undriven, rpt_untouched;
  logic [4:0]    rpt_flag_cnt;

  logic          s_wr_en, s_wr_mask, s_rd_en, s_rd_mask, s_clear, s_req, s_ready;
  logic          s_busy, s_valid, s_done;
  logic [0:0]    s_chan, s_unused, s_undriven, s_untouched, s_cnt;

  bit_usage_monitor #(.WIDTH(W), .NCH(N)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_mask(wr_mask), .rd_en(rd_en),
    .rd_mask(rd_mask), .clear(clear), .report_req(report_req), .busy(busy),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_chan(rpt_chan),
    .rpt_unused(rpt_unused), .rpt_undriven(rpt_undriven),
    .rpt_untouched(rpt_untouched), .rpt_flag_cnt(rpt_flag_cnt), .done(done)
  );

  bit_usage_monitor #(.WIDTH(1), .NCH(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_mask(s_wr_mask), .rd_en(s_rd_en),
    .rd_mask(s_rd_mask), .clear(s_clear), .report_req(s_req), .busy(s_busy),
    .rpt_valid(s_valid), .rpt_ready(s_ready), .rpt_chan(s_chan),
    .rpt_unused(s_unused), .rpt_undriven(s_undriven),
    .rpt_untouched(s_untouched), .rpt_flag_cnt(s_cnt), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          chan;
    logic [W-1:0] un, ud, ut;
    int          cnt;
  } beat_t;

  beat_t        q[$];
  logic [W-1:0] m_drv [N];
  logic [W-1:0] m_use [N];
  bit           m_busy, m_done;

  int           n_tests, n_fail, n_xfer, n_done;
  logic [W-1:0] cap_un [N];
  logic [W-1:0] cap_ud [N];
  logic [W-1:0] cap_ut [N];
  int           cap_cnt [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int c = 0; c < N; c++) begin
      m_drv[c] = '0;
      m_use[c] = '0;
    end
    m_busy = 0;
    m_done = 0;
  endtask

  // advance the model by one clock using the inputs present at the edge
  task automatic model_step();
    bit    was_busy, was_done;
    beat_t b;
    if (rst) begin
      model_reset();
      return;
    end
    was_busy = m_busy;
    was_done = m_done;
    m_done   = 0;
    if (q.size() > 0 && rpt_ready) begin
      void'(q.pop_front());
      if (q.size() == 0) m_done = 1;
    end
    if (was_done) m_busy = 0;
    for (int c = 0; c < N; c++) begin
      if (clear) begin
        m_drv[c] = '0;
        m_use[c] = '0;
      end
      if (wr_en[c]) m_drv[c] |= wr_mask[c*W +: W];
      if (rd_en[c]) m_use[c] |= rd_mask[c*W +: W];
    end
    if (!was_busy && report_req) begin
      for (int c = 0; c < N; c++) begin
        b.chan = c;
        b.un   = m_drv[c] & ~m_use[c];
        b.ud   = m_use[c] & ~m_drv[c];
        b.ut   = ~(m_drv[c] | m_use[c]);
        b.cnt  = $countones(b.un | b.ud);
        q.push_back(b);
      end
      m_busy = 1;
    end
  endtask

  task automatic compare_all();
    bit v;
    v = (q.size() > 0);
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("rpt_valid", {31'd0, rpt_valid}, {31'd0, v});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("rpt_chan", {31'd0, rpt_chan}, v ? q[0].chan : 0);
    check("rpt_unused", {16'd0, rpt_unused}, v ? {16'd0, q[0].un} : 32'd0);
    check("rpt_undriven", {16'd0, rpt_undriven}, v ? {16'd0, q[0].ud} : 32'd0);
    check("rpt_untouched", {16'd0, rpt_untouched}, v ? {16'd0, q[0].ut} : 32'd0);
    check("rpt_flag_cnt", {27'd0, rpt_flag_cnt}, v ? q[0].cnt : 0);
    if (rpt_valid) begin
      cap_un[rpt_chan]  = rpt_unused;
      cap_ud[rpt_chan]  = rpt_undriven;
      cap_ut[rpt_chan]  = rpt_untouched;
      cap_cnt[rpt_chan] = int'(rpt_flag_cnt);
    end
  endtask

  task automatic cyc();
    if (rpt_valid && rpt_ready) n_xfer++;
    if (done) n_done++;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic quiet();
    wr_en = '0; rd_en = '0; wr_mask = '0; rd_mask = '0;
    clear = 0; report_req = 0; rpt_ready = 1;
  endtask

  task automatic run_report();
    report_req = 1;
    cyc();
    report_req = 0;
    repeat (3) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; n_xfer = 0; n_done = 0;
    quiet();
    s_wr_en = 0; s_wr_mask = 0; s_rd_en = 0; s_rd_mask = 0;
    s_clear = 0; s_req = 0; s_ready = 1;
    rst = 1;
    #3;
    model_reset();
    compare_all();
    cyc();
    rst = 0;
    cyc();

    // no traffic: all bits untouched, done in the third cycle after the request
    report_req = 1;
    cyc();
    report_req = 0;
    check("t1_busy_c1", {31'd0, busy}, 32'd1);
    cyc();
    cyc();
    check("t1_done_c3", {31'd0, done}, 32'd1);
    cyc();
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    check("t1_ut0", {16'd0, cap_ut[0]}, 32'h0000FFFF);
    check("t1_ut1", {16'd0, cap_ut[1]}, 32'h0000FFFF);
    check("t1_cnt0", cap_cnt[0], 0);

    // mixed pattern
    wr_en = 2'b11; wr_mask = {16'h9400, 16'h003F};
    rd_en = 2'b11; rd_mask = {16'hF400, 16'h000B};
    cyc();
    quiet();
    run_report();
    check("t2_un0", {16'd0, cap_un[0]}, 32'h0034);
    check("t2_ud0", {16'd0, cap_ud[0]}, 32'h0000);
    check("t2_ut0", {16'd0, cap_ut[0]}, 32'hFFC0);
    check("t2_cnt0", cap_cnt[0], 3);
    check("t2_un1", {16'd0, cap_un[1]}, 32'h0000);
    check("t2_ud1", {16'd0, cap_ud[1]}, 32'h6000);
    check("t2_ut1", {16'd0, cap_ut[1]}, 32'h0BFF);
    check("t2_cnt1", cap_cnt[1], 2);

    // strobe gating, then clear merged with a same-cycle write
    clear = 1;
    cyc();
    clear = 0; wr_en = 2'b00; wr_mask = '1;
    cyc();
    quiet();
    run_report();
    check("t3_gate_ut0", {16'd0, cap_ut[0]}, 32'hFFFF);
    check("t3_gate_ut1", {16'd0, cap_ut[1]}, 32'hFFFF);
    wr_en = 2'b11; wr_mask = 32'hAAAA_5555;
    cyc();
    clear = 1; wr_en = 2'b01; wr_mask = 32'h0000_0001;
    cyc();
    quiet();
    run_report();
    check("t3_clr_un0", {16'd0, cap_un[0]}, 32'h0001);
    check("t3_clr_ut0", {16'd0, cap_ut[0]}, 32'hFFFE);
    check("t3_clr_ut1", {16'd0, cap_ut[1]}, 32'hFFFF);

    // backpressure with traffic and an ignored mid-scan request
    wr_en = 2'b01; wr_mask = 32'h0000_00F0;
    cyc();
    quiet();
    n_xfer = 0; n_done = 0;
    report_req = 1;
    cyc();
    report_req = 0;
    rpt_ready = 0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 2'b11; wr_mask = $urandom(); rd_en = 2'b11; rd_mask = $urandom();
      report_req = (i == 2);
      cyc();
      check("t4_hold_chan", {31'd0, rpt_chan}, 32'd0);
    end
    quiet();
    report_req = 1;
    cyc();
    report_req = 0;
    repeat (5) cyc();
    check("t4_beats", n_xfer, 2);
    check("t4_dones", n_done, 1);

    // reset while beat for channel 1 is on the bus
    clear = 1;
    cyc();
    quiet();
    wr_en = 2'b11; wr_mask = '1;
    cyc();
    quiet();
    report_req = 1;
    cyc();
    report_req = 0;
    cyc();
    check("t5_on_ch1", {31'd0, rpt_chan}, 32'd1);
    rst = 1;
    #2;
    model_reset();
    compare_all();
    n_done = 0;
    cyc();
    rst = 0;
    repeat (3) cyc();
    check("t5_no_done", n_done, 0);
    run_report();
    check("t5_ut0", {16'd0, cap_ut[0]}, 32'hFFFF);
    check("t5_ut1", {16'd0, cap_ut[1]}, 32'hFFFF);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      wr_en      = 2'($urandom());
      rd_en      = 2'($urandom());
      wr_mask    = $urandom();
      rd_mask    = $urandom() & $urandom();
      clear      = ($urandom_range(15) == 0);
      report_req = ($urandom_range(7) == 0);
      rpt_ready  = ($urandom_range(3) != 0);
      cyc();
    end
    quiet();
    repeat (6) cyc();

    // single-channel, single-bit build
    s_wr_en = 1; s_wr_mask = 1; s_rd_en = 1; s_rd_mask = 1;
    @(posedge clk); #1;
    s_wr_en = 0; s_rd_en = 0; s_req = 1;
    @(posedge clk); #1;
    s_req = 0;
    check("n1_valid", {31'd0, s_valid}, 32'd1);
    check("n1_chan", {31'd0, s_chan}, 32'd0);
    check("n1_unused", {31'd0, s_unused}, 32'd0);
    check("n1_undriven", {31'd0, s_undriven}, 32'd0);
    check("n1_untouched", {31'd0, s_untouched}, 32'd0);
    check("n1_cnt", {31'd0, s_cnt}, 32'd0);
    @(posedge clk); #1;
    check("n1_done", {31'd0, s_done}, 32'd1);
    check("n1_valid_off", {31'd0, s_valid}, 32'd0);
    @(posedge clk); #1;
    check("n1_idle", {31'd0, s_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
